// File: rtl/i2s_rx_16lj32_regen_if.sv
// rtl/i2s_rx_16lj32_regen_if.sv - I2S input / 16LJ output signal bundle
// Purpose: groups the external I2S inputs and the regenerated 16LJ outputs.
// Signals:
//   ext_bck, ext_lrck, ext_data - asynchronous I2S input (lrck low = left)
//   bck_701, lrck_701, data_701 - regenerated 16LJ 32fs output (lrck high = left)
//   locked                      - input frame structure valid
// Modports:
//   master - I2S source / output sink side
//   slave  - receiver/regenerator side
interface i2s_rx_16lj32_regen_if;
  logic ext_bck;
  logic ext_lrck;
  logic ext_data;
  logic bck_701;
  logic lrck_701;
  logic data_701;
  logic locked;

  modport master (
    output ext_bck, ext_lrck, ext_data,
    input  bck_701, lrck_701, data_701, locked
  );

  modport slave (
    input  ext_bck, ext_lrck, ext_data,
    output bck_701, lrck_701, data_701, locked
  );
endinterface

// File: rtl/i2s_rx_16lj32_regen.sv
// rtl/i2s_rx_16lj32_regen.sv - Oversampling I2S receiver and 16LJ 32fs regenerator
// Purpose: oversamples an external I2S stream on mck, captures the top 16 bits
//   of each channel and re-emits complete frames as 16-bit left-justified 32fs.
// Ports:
//   mck   - system clock, at least 4x ext_bck
//   rst_n - synchronous active-low reset
//   bus   - slave modport: ext_bck/ext_lrck/ext_data in,
//           bck_701/lrck_701/data_701/locked out
module i2s_rx_16lj32_regen #(
  parameter int HALF_BCK    = 8,
  parameter int TIMEOUT     = 1024,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  mck,
  input  logic                  rst_n,
  i2s_rx_16lj32_regen_if.slave  bus
);
  localparam int PHW = $clog2(2 * HALF_BCK);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int CW  = $clog2(LOCK_FRAMES + 1);

  // Two-stage synchronizers; stage [1] is the usable value.
  logic [1:0]    bck_s_q, lr_s_q, dat_s_q;
  logic          bck_prev_q;

  // Receiver state. sr holds the previous 31 bits; the incoming bit completes
  // the 32-bit window, so the oldest bit never needs to be stored.
  logic [30:0]   sr_q, sr_d;
  logic          lr_q, lr_d;
  logic [5:0]    n_q, n_d;
  logic [15:0]   l_in_q, l_in_d;
  logic          left_ok_q, left_ok_d;
  logic [31:0]   frame_q, frame_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;

  // Output generator state.
  logic [PHW-1:0] ph_q, ph_d;
  logic [4:0]     bit_q, bit_d;
  logic [31:0]    out_q, out_d;
  logic           bck_o_q, bck_o_d;
  logic           lrck_o_q, lrck_o_d;
  logic           data_o_q, data_o_d;

  logic        bck_rise;
  logic        lr_change;
  logic [31:0] sr_shift;
  logic [5:0]  shift_amt;
  logic [15:0] word16;
  logic        half_valid;
  logic        locked_w;
  logic        frame_start;
  logic [31:0] cur_buf;

  assign bck_rise   = bck_s_q[1] & ~bck_prev_q;
  assign lr_change  = lr_s_q[1] != lr_q;
  assign sr_shift   = {sr_q, dat_s_q[1]};
  // N = n+1 and the word occupies sr[N-1 -: 16], i.e. shift right by N-16.
  assign half_valid = (n_q >= 6'd15) && (n_q <= 6'd31);
  assign shift_amt  = n_q - 6'd15;
  assign word16     = 16'(sr_shift >> shift_amt);
  assign locked_w   = (cnt_q == CW'(LOCK_FRAMES));

  assign frame_start = (ph_q == '0) && (bit_q == 5'd0);
  // The buffer loaded at frame start must already drive bit 0 on that edge.
  assign cur_buf     = frame_start ? (locked_w ? frame_q : 32'd0) : out_q;

  always_comb begin
    sr_d      = sr_q;
    lr_d      = lr_q;
    n_d       = n_q;
    l_in_d    = l_in_q;
    left_ok_d = left_ok_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;

    if (bck_rise) begin
      sr_d   = sr_shift[30:0];
      lr_d   = lr_s_q[1];
      idle_d = '0;
      if (lr_change) begin
        n_d = 6'd0;
        if (!half_valid) begin
          cnt_d = '0;
        end
        if (lr_s_q[1]) begin
          l_in_d    = word16;
          left_ok_d = half_valid;
        end else if (half_valid && left_ok_q) begin
          frame_d = {l_in_q, word16};
          if (cnt_q != CW'(LOCK_FRAMES)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end else if (n_q != 6'd63) begin
        n_d = n_q + 6'd1;
      end
    end else if (idle_q != TW'(TIMEOUT)) begin
      idle_d = idle_q + TW'(1);
    end

    if (idle_d == TW'(TIMEOUT)) begin
      cnt_d = '0;
    end

    ph_d  = (ph_q == PHW'(2 * HALF_BCK - 1)) ? '0 : ph_q + PHW'(1);
    bit_d = (ph_q == PHW'(2 * HALF_BCK - 1)) ? bit_q + 5'd1 : bit_q;
    out_d = cur_buf;
    bck_o_d  = (ph_q >= PHW'(HALF_BCK));
    lrck_o_d = ~bit_q[4];
    // L[15-bit] for bits 0..15 and R[31-bit] for 16..31 both equal buf[31-bit].
    data_o_d = cur_buf[~bit_q];
  end

  always_ff @(posedge mck) begin
    if (!rst_n) begin
      bck_s_q    <= '0;
      lr_s_q     <= '0;
      dat_s_q    <= '0;
      bck_prev_q <= 1'b0;
      sr_q       <= '0;
      lr_q       <= 1'b0;
      n_q        <= '0;
      l_in_q     <= '0;
      left_ok_q  <= 1'b0;
      frame_q    <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      ph_q       <= '0;
      bit_q      <= '0;
      out_q      <= '0;
      bck_o_q    <= 1'b0;
      lrck_o_q   <= 1'b1;
      data_o_q   <= 1'b0;
    end else begin
      bck_s_q    <= {bck_s_q[0], bus.ext_bck};
      lr_s_q     <= {lr_s_q[0], bus.ext_lrck};
      dat_s_q    <= {dat_s_q[0], bus.ext_data};
      bck_prev_q <= bck_s_q[1];
      sr_q       <= sr_d;
      lr_q       <= lr_d;
      n_q        <= n_d;
      l_in_q     <= l_in_d;
      left_ok_q  <= left_ok_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      out_q      <= out_d;
      bck_o_q    <= bck_o_d;
      lrck_o_q   <= lrck_o_d;
      data_o_q   <= data_o_d;
    end
  end

  assign bus.bck_701  = bck_o_q;
  assign bus.lrck_701 = lrck_o_q;
  assign bus.data_701 = data_o_q;
  assign bus.locked   = locked_w;
endmodule
